// File: rtl/rsa_sched_pkg.sv
// -----------------------------------------------------------------------------
// rsa_sched_pkg
// Shared definitions for the rsa_unit job scheduler.
//   state_t   : scheduler FSM states
//   GPIO_IDX  : requester index of the GPIO command decoder
//   SPI_IDX   : requester index of the SPI command decoder
// -----------------------------------------------------------------------------
package rsa_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN    = 3'd1,
        CLREL = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam int GPIO_IDX = 0;
    localparam int SPI_IDX  = 1;

endpackage

// File: rtl/rsa_job_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rsa_rr_pick
// Combinational round-robin selector.
//   req    in   NUM_REQ  pending requests
//   ptr    in   PW       index of the most recent winner
//   winner out  NUM_REQ  one-hot winner, searched from ptr+1 upward with wrap
//   valid  out  1        at least one request pending
// -----------------------------------------------------------------------------
module rsa_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    // Walk the requesters starting just after the last winner; the first
    // pending one wins, so the last winner is always considered last.
    always_comb begin : search
        logic          found;
        logic [PW-1:0] cand;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                winner[cand] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/rsa_job_scheduler.sv
// -----------------------------------------------------------------------------
// rsa_job_scheduler
// Shares one rsa_unit between NUM_REQ requesters with round-robin arbitration,
// sequences enable / clear-release / run, and reports done or timeout.
//   clk        in   1        clock
//   rst        in   1        asynchronous reset, active-high
//   ena        in   1        global enable; low freezes all state
//   req        in   NUM_REQ  level job request per requester
//   abort      in   NUM_REQ  cancel; honoured only for the granted index
//   grant      out  NUM_REQ  one-hot owner of rsa_unit (registered)
//   done       out  NUM_REQ  1-cycle completion pulse to the owner
//   err        out  NUM_REQ  1-cycle timeout pulse to the owner
//   busy       out  1        scheduler not idle
//   en_rsa     out  1        rsa_unit enable
//   clear_rsa  out  1        0 holds rsa_unit cleared, 1 releases it
//   eoc_rsa    in   1        end of conversion from rsa_unit
// -----------------------------------------------------------------------------
module rsa_job_scheduler
    import rsa_sched_pkg::*;
#(
    parameter int                  NUM_REQ  = 2,
    parameter int                  TO_WIDTH = 16,
    parameter logic [TO_WIDTH-1:0] TO_LIMIT = 16'd4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] abort,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err,
    output logic               busy,
    output logic               en_rsa,
    output logic               clear_rsa,
    input  logic               eoc_rsa
);

    localparam int                  PW      = $clog2(NUM_REQ);
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_LIMIT - 1'b1;
    localparam logic                TO_ON   = (TO_LIMIT != '0);

    state_t              state, state_nx;
    logic [NUM_REQ-1:0]  grant_nx;
    logic [PW-1:0]       ptr, ptr_nx;
    logic [TO_WIDTH-1:0] to_cnt, to_cnt_nx;

    logic [NUM_REQ-1:0]  pick_winner;
    logic                pick_valid;
    logic [PW-1:0]       pick_idx;
    logic                owner_abort;

    rsa_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Convert the one-hot winner back to an index for the rr pointer.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_winner[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    // Abort only counts when it targets the current owner.
    assign owner_abort = |(abort & grant);

    // Next-state logic. Every path back to IDLE also drops grant, so a
    // job always ends with at least one idle cycle before the next grant.
    // In RUN a completed conversion beats abort, which beats timeout.
    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        ptr_nx    = ptr;
        to_cnt_nx = to_cnt;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nx = pick_winner;
                    ptr_nx   = pick_idx;
                    state_nx = EN;
                end
            end
            EN: begin
                if (owner_abort) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end else begin
                    state_nx = CLREL;
                end
            end
            CLREL: begin
                if (owner_abort) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end else begin
                    state_nx  = RUN;
                    to_cnt_nx = '0;
                end
            end
            RUN: begin
                if (eoc_rsa) begin
                    state_nx = DONE;
                end else if (owner_abort) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end else if (TO_ON && to_cnt == TO_LAST) begin
                    state_nx = ERR;
                end else if (TO_ON && to_cnt != '1) begin
                    to_cnt_nx = to_cnt + 1'b1;
                end
            end
            DONE, ERR: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    // State registers; ena low holds everything, including the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            ptr    <= PW'(NUM_REQ - 1);
            to_cnt <= '0;
        end else if (ena) begin
            state  <= state_nx;
            grant  <= grant_nx;
            ptr    <= ptr_nx;
            to_cnt <= to_cnt_nx;
        end
    end

    // Outputs are pure decodes of registered state so they hold while frozen.
    assign busy      = (state != IDLE);
    assign en_rsa    = (state == EN) || (state == CLREL) || (state == RUN) || (state == DONE);
    assign clear_rsa = (state == CLREL) || (state == RUN) || (state == DONE);
    assign done      = (state == DONE) ? grant : '0;
    assign err       = (state == ERR)  ? grant : '0;

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rsa_job_scheduler
// Self-checking bench for rsa_job_scheduler. The main instance uses a short
// timeout so random traffic reaches every outcome; a second instance with
// TO_LIMIT=8 gets a directed timeout sequence.
// -----------------------------------------------------------------------------
module tb_rsa_job_scheduler;

    localparam int LIMIT_MAIN = 12;

    logic       clk;
    logic       rst, ena, eoc_rsa;
    logic [1:0] req, abort;
    logic [1:0] grant, done, err;
    logic       busy, en_rsa, clear_rsa;

    logic       rst_t, ena_t, eoc_t;
    logic [1:0] req_t, abort_t;
    logic [1:0] grant_t, done_t, err_t;
    logic       busy_t, en_t, clear_t;

    int checks = 0;
    int errors = 0;

    // Job-level reference model: who owns the unit, how many cycles since
    // the grant, and whether the job is in its final reporting cycle.
    int m_owner;
    int m_age;
    int m_fin;
    int m_last;

    typedef struct {
        logic [1:0] req;
        logic [1:0] abort;
        logic       eoc;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[18];

    rsa_job_scheduler #(
        .NUM_REQ  (2),
        .TO_WIDTH (16),
        .TO_LIMIT (16'(LIMIT_MAIN))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .abort     (abort),
        .grant     (grant),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .en_rsa    (en_rsa),
        .clear_rsa (clear_rsa),
        .eoc_rsa   (eoc_rsa)
    );

    rsa_job_scheduler #(
        .NUM_REQ  (2),
        .TO_WIDTH (16),
        .TO_LIMIT (16'd8)
    ) dut8 (
        .clk       (clk),
        .rst       (rst_t),
        .ena       (ena_t),
        .req       (req_t),
        .abort     (abort_t),
        .grant     (grant_t),
        .done      (done_t),
        .err       (err_t),
        .busy      (busy_t),
        .en_rsa    (en_t),
        .clear_rsa (clear_t),
        .eoc_rsa   (eoc_t)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] mk(input logic [1:0] g, input logic [1:0] d,
                                      input logic [1:0] e, input logic b,
                                      input logic en, input logic c);
        return {g, d, e, b, en, c};
    endfunction

    function automatic logic [8:0] actMain();
        return {grant, done, err, busy, en_rsa, clear_rsa};
    endfunction

    function automatic logic [8:0] act8();
        return {grant_t, done_t, err_t, busy_t, en_t, clear_t};
    endfunction

    function automatic logic [8:0] modelOut();
        logic [1:0] g;
        logic       b, e, c;
        g = (m_owner >= 0) ? 2'(2'b01 << m_owner) : 2'b00;
        b = (m_owner >= 0);
        e = b && (m_fin != 2);
        c = e && (m_fin == 1 || m_age >= 1);
        return {g, (m_fin == 1) ? g : 2'b00, (m_fin == 2) ? g : 2'b00, b, e, c};
    endfunction

    task automatic modelReset();
        m_owner = -1;
        m_age   = 0;
        m_fin   = 0;
        m_last  = 1;
    endtask

    // One clock of the reference: finish reporting, arbitrate, or advance.
    task automatic modelStep();
        logic ab;
        if (m_owner >= 0 && m_fin != 0) begin
            m_owner = -1;
            m_fin   = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 2; k++) begin
                int c;
                c = (m_last + k) % 2;
                if (m_owner < 0 && ((req >> c) & 2'b01) != 2'b00) begin
                    m_owner = c;
                    m_last  = c;
                    m_age   = 0;
                end
            end
        end else begin
            ab = (((abort >> m_owner) & 2'b01) != 2'b00);
            if (m_age < 2) begin
                if (ab) m_owner = -1;
                else    m_age++;
            end else if (eoc_rsa) begin
                m_fin = 1;
            end else if (ab) begin
                m_owner = -1;
            end else if (LIMIT_MAIN != 0 && (m_age - 2) == LIMIT_MAIN - 1) begin
                m_fin = 2;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got grant=%b done=%b err=%b busy=%b en=%b clr=%b, expected grant=%b done=%b err=%b busy=%b en=%b clr=%b",
                     name, $time, act[8:7], act[6:5], act[4:3], act[2], act[1], act[0],
                     exp[8:7], exp[6:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] a,
                                 input logic e, input logic en_in);
        req     = r;
        abort   = a;
        eoc_rsa = e;
        ena     = en_in;
    endtask

    // Advance one clock and compare the main instance with the model.
    task automatic step();
        @(posedge clk);
        if (ena) modelStep();
        #1;
        checkOutput("model", actMain(), modelOut());
    endtask

    // Mid-cycle asynchronous reset of the main instance.
    task automatic doReset(input int dly);
        #(dly);
        rst = 1'b1;
        #1;
        checkOutput("rst_async", actMain(), 9'b0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [8:0] idle0;
        logic [1:0] g;
        idle0 = 9'b0;

        // Directed table: aborts, eoc/abort collision, rr order, idle gaps.
        tbl[0]  = '{2'b01, 2'b00, 1'b0, mk(2'b01, 2'b00, 2'b00, 1, 1, 0)};
        tbl[1]  = '{2'b00, 2'b10, 1'b0, mk(2'b01, 2'b00, 2'b00, 1, 1, 1)};
        tbl[2]  = '{2'b00, 2'b00, 1'b0, mk(2'b01, 2'b00, 2'b00, 1, 1, 1)};
        tbl[3]  = '{2'b00, 2'b01, 1'b0, idle0};
        tbl[4]  = '{2'b10, 2'b00, 1'b0, mk(2'b10, 2'b00, 2'b00, 1, 1, 0)};
        tbl[5]  = '{2'b00, 2'b00, 1'b0, mk(2'b10, 2'b00, 2'b00, 1, 1, 1)};
        tbl[6]  = '{2'b00, 2'b00, 1'b0, mk(2'b10, 2'b00, 2'b00, 1, 1, 1)};
        tbl[7]  = '{2'b00, 2'b10, 1'b1, mk(2'b10, 2'b10, 2'b00, 1, 1, 1)};
        tbl[8]  = '{2'b00, 2'b00, 1'b0, idle0};
        tbl[9]  = '{2'b11, 2'b00, 1'b0, mk(2'b01, 2'b00, 2'b00, 1, 1, 0)};
        tbl[10] = '{2'b11, 2'b00, 1'b0, mk(2'b01, 2'b00, 2'b00, 1, 1, 1)};
        tbl[11] = '{2'b11, 2'b00, 1'b0, mk(2'b01, 2'b00, 2'b00, 1, 1, 1)};
        tbl[12] = '{2'b11, 2'b00, 1'b1, mk(2'b01, 2'b01, 2'b00, 1, 1, 1)};
        tbl[13] = '{2'b11, 2'b00, 1'b0, idle0};
        tbl[14] = '{2'b11, 2'b00, 1'b0, mk(2'b10, 2'b00, 2'b00, 1, 1, 0)};
        tbl[15] = '{2'b11, 2'b10, 1'b0, idle0};
        tbl[16] = '{2'b11, 2'b00, 1'b0, mk(2'b01, 2'b00, 2'b00, 1, 1, 0)};
        tbl[17] = '{2'b11, 2'b01, 1'b0, idle0};

        rst = 1'b1;
        rst_t = 1'b1;
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
        req_t = 2'b00; abort_t = 2'b00; eoc_t = 1'b0; ena_t = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_main", actMain(), 9'b0);
        checkOutput("reset_t8", act8(), 9'b0);
        rst = 1'b0;
        rst_t = 1'b0;

        $display("[TB] directed table");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].req, tbl[i].abort, tbl[i].eoc, 1'b1);
            step();
            checkOutput($sformatf("table_row%0d", i), actMain(), tbl[i].exp);
        end

        $display("[TB] single job, eoc after 10 run cycles");
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b1);
        step();
        checkOutput("t1_en", actMain(), mk(2'b01, 2'b00, 2'b00, 1, 1, 0));
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
        step();
        checkOutput("t1_clrel", actMain(), mk(2'b01, 2'b00, 2'b00, 1, 1, 1));
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("t1_run", actMain(), mk(2'b01, 2'b00, 2'b00, 1, 1, 1));
        end
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1);
        step();
        checkOutput("t1_done", actMain(), mk(2'b01, 2'b01, 2'b00, 1, 1, 1));
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
        step();
        checkOutput("t1_idle", actMain(), idle0);

        $display("[TB] three jobs with both requesters pending");
        doReset(0);
        for (int j = 0; j < 3; j++) begin
            g = (j == 1) ? 2'b10 : 2'b01;
            applyStimulus(2'b11, 2'b00, 1'b0, 1'b1);
            step();
            checkOutput("t2_grant", actMain(), mk(g, 2'b00, 2'b00, 1, 1, 0));
            step();
            step();
            applyStimulus(2'b11, 2'b00, 1'b1, 1'b1);
            step();
            checkOutput("t2_done", actMain(), mk(g, g, 2'b00, 1, 1, 1));
            applyStimulus(2'b11, 2'b00, 1'b0, 1'b1);
            step();
            checkOutput("t2_gap", actMain(), idle0);
        end
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
        step();

        $display("[TB] timeout with TO_LIMIT=8");
        req_t = 2'b01;
        step();
        checkOutput("t3_en", act8(), mk(2'b01, 2'b00, 2'b00, 1, 1, 0));
        req_t = 2'b00;
        step();
        step();
        checkOutput("t3_run1", act8(), mk(2'b01, 2'b00, 2'b00, 1, 1, 1));
        for (int i = 0; i < 7; i++) begin
            step();
            checkOutput("t3_run", act8(), mk(2'b01, 2'b00, 2'b00, 1, 1, 1));
        end
        step();
        checkOutput("t3_err", act8(), mk(2'b01, 2'b00, 2'b01, 1, 0, 0));
        step();
        checkOutput("t3_idle", act8(), idle0);

        $display("[TB] enable freeze mid-run");
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b1);
        step();
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b00, 2'b10, 1'b1, 1'b0);
            step();
            checkOutput("t5_frozen", actMain(), mk(2'b10, 2'b00, 2'b00, 1, 1, 1));
        end
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("t5_resume", actMain(), mk(2'b10, 2'b00, 2'b00, 1, 1, 1));
        end
        step();
        checkOutput("t5_timeout", actMain(), mk(2'b10, 2'b00, 2'b10, 1, 0, 0));
        step();

        $display("[TB] reset mid-run");
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b1);
        step();
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
        step();
        step();
        doReset(3);
        applyStimulus(2'b11, 2'b00, 1'b0, 1'b1);
        step();
        checkOutput("t6_first_grant", actMain(), mk(2'b01, 2'b00, 2'b00, 1, 1, 0));

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 9) != 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
